// File: rtl/bfis_query_ctrl_pkg.sv
// Shared types and constants for the bfis query sequencer.
// Provides the FSM state enum, the frame sentinel and the frame-index width helper.
package bfis_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        DRAIN
    } state_t;

    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

    // A frame is DIM query words, then k, then the vertex id.
    function automatic int frame_idx_w(input int dim);
        return $clog2(dim + 2);
    endfunction

endpackage

// File: rtl/bfis_query_ctrl_if.sv
// Host mailbox channel: word strobe in, buffered result readout back.
// master = host side (drives word_in/word_valid_in/rd_in), slave = controller.
interface bfis_query_ctrl_if;

    logic [31:0] word_in;
    logic        word_valid_in;
    logic [31:0] result_out;
    logic        result_valid_out;
    logic        rd_in;

    modport master (
        output word_in,
        output word_valid_in,
        output rd_in,
        input  result_out,
        input  result_valid_out
    );

    modport slave (
        input  word_in,
        input  word_valid_in,
        input  rd_in,
        output result_out,
        output result_valid_out
    );

endinterface

// File: rtl/bfis_query_ctrl_result_fifo.sv
// Result buffer: synchronous FIFO with first-word-fall-through head.
// Ports: clk, rst_n, push/din, pop, flush, head, empty, count.
module bfis_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (cnt != CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (cnt != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (!do_push && do_pop)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/bfis_query_ctrl.sv
// Query sequencer: assembles a host frame, launches the engine, buffers k results.
// Ports: clk_in/rst_in, host mailbox (slave), engine query/k/vertex/start, results, status.
// Optional watchdog in RUN enabled by macro BFIS_CTRL_TIMEOUT_EN.
module bfis_query_ctrl
    import bfis_ctrl_pkg::*;
#(
    parameter int DIM            = 4,
    parameter int MAX_K          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bfis_query_ctrl_if.slave     host,
    output logic [DIM-1:0][31:0] query_out,
    output logic [15:0]          k_out,
    output logic [31:0]          vertex_id_out,
    output logic                 start_out,
    input  logic [31:0]          res_data_in,
    input  logic                 res_valid_in,
    output logic [31:0]          cycles_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out
);

    localparam int IW = frame_idx_w(DIM);
    localparam int CW = $clog2(MAX_K + 1);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [DIM-1:0][31:0] q_buf;
    logic [15:0]          k_buf;

    logic        sent;
    logic        data_w;
    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] head;
    logic        empty;
    logic [CW-1:0] count;
    logic [31:0] cyc_nxt;
    logic        bad_k;
    logic        k_hit;
    logic        tmo;

    assign sent   = host.word_valid_in && (host.word_in == SENTINEL);
    assign data_w = host.word_valid_in && (host.word_in != SENTINEL);

    assign push  = (state == RUN) && res_valid_in;
    assign pop   = (state == DRAIN) && !sent && host.rd_in && !empty;
    assign flush = (state == DRAIN) && sent;

    bfis_result_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_K)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (push),
        .din   (res_data_in),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    assign cyc_nxt = (cycles_out == '1) ? cycles_out : cycles_out + 1'b1;
    assign bad_k   = (k_buf == '0) || (k_buf > 16'(MAX_K));

    // The buffer is always empty at launch, so its fill level doubles as
    // the per-query result counter while in RUN.
    assign k_hit = push && ((32'(count) + 32'd1) == 32'(k_out));

`ifdef BFIS_CTRL_TIMEOUT_EN
    assign tmo = (cyc_nxt >= 32'(TIMEOUT_CYCLES));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            idx           <= '0;
            q_buf         <= '0;
            k_buf         <= '0;
            query_out     <= '0;
            k_out         <= '0;
            vertex_id_out <= '0;
            start_out     <= 1'b0;
            cycles_out    <= '0;
            done_out      <= 1'b0;
            error_out     <= 1'b0;
        end else begin
            start_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sent) begin
                        state     <= LOAD;
                        idx       <= '0;
                        done_out  <= 1'b0;
                        error_out <= 1'b0;
                    end
                end
                LOAD: begin
                    if (sent) begin
                        idx <= '0;
                    end else if (data_w) begin
                        for (int i = 0; i < DIM; i++)
                            if (idx == IW'(i)) q_buf[i] <= host.word_in;
                        if (idx == IW'(DIM))
                            k_buf <= host.word_in[15:0];
                        if (idx == IW'(DIM + 1)) begin
                            idx <= '0;
                            if (bad_k) begin
                                error_out <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                query_out     <= q_buf;
                                k_out         <= k_buf;
                                vertex_id_out <= host.word_in;
                                start_out     <= 1'b1;
                                state         <= LAUNCH;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    cycles_out <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    cycles_out <= cyc_nxt;
                    if (k_hit) begin
                        state <= DRAIN;
                    end else if (tmo) begin
                        error_out <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sent) begin
                        idx   <= '0;
                        state <= LOAD;
                    end else if (empty) begin
                        done_out <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_out              = (state != IDLE);
    assign host.result_valid_out = (state == DRAIN) && !empty;
    assign host.result_out       = host.result_valid_out ? head : '0;

endmodule

// File: tb/tb_bfis_query_ctrl.sv
// Self-checking bench for bfis_query_ctrl: directed, table-driven and random queries.
// Timeout scenario is compiled only with BFIS_CTRL_TIMEOUT_EN.
module tb_bfis_query_ctrl;
    import bfis_ctrl_pkg::*;

    localparam int DIM   = 4;
    localparam int MAX_K = 8;

    typedef logic [DIM-1:0][31:0] qvec_t;

    typedef struct {
        logic [31:0] kw;
        bit          ok;
    } kvec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    qvec_t       query_out;
    logic [15:0] k_out;
    logic [31:0] vertex_id_out;
    logic        start_out;
    logic [31:0] res_data_in;
    logic        res_valid_in;
    logic [31:0] cycles_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    bfis_query_ctrl_if host();

    always #5 clk_in = ~clk_in;

    bfis_query_ctrl #(
        .DIM            (DIM),
        .MAX_K          (MAX_K),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .host          (host),
        .query_out     (query_out),
        .k_out         (k_out),
        .vertex_id_out (vertex_id_out),
        .start_out     (start_out),
        .res_data_in   (res_data_in),
        .res_valid_in  (res_valid_in),
        .cycles_out    (cycles_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .error_out     (error_out)
    );

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int last_cyc;
    logic [31:0] exp_q[$];
    kvec_t tbl[7];

    always @(negedge clk_in) if (start_out) starts++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        host.word_in       = w;
        host.word_valid_in = 1'b1;
        step();
        host.word_valid_in = 1'b0;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SENTINEL) w = 32'h0;
        return w;
    endfunction

    task automatic send_body(input qvec_t q, input logic [31:0] kw,
                             input logic [31:0] vid, input bit gaps);
        for (int i = 0; i < DIM; i++) begin
            send(q[i]);
            if (gaps && $urandom_range(0, 2) == 0) step();
        end
        send(kw);
        if (gaps && $urandom_range(0, 2) == 0) step();
        send(vid);
    endtask

    task automatic send_frame(input qvec_t q, input logic [31:0] kw,
                              input logic [31:0] vid, input bit gaps);
        send(SENTINEL);
        chk("sent_clr_err", error_out, 0);
        chk("sent_clr_done", done_out, 0);
        send_body(q, kw, vid, gaps);
    endtask

    task automatic chk_launch(input qvec_t q, input logic [31:0] kw,
                              input logic [31:0] vid);
        chk("start", start_out, 1);
        for (int i = 0; i < DIM; i++) chk("query", query_out[i], q[i]);
        chk("k", 32'(k_out), 32'(kw[15:0]));
        chk("vid", vertex_id_out, vid);
        chk("busy_launch", busy_out, 1);
        chk("err_launch", error_out, 0);
    endtask

    // From LAUNCH: deliver k results at random RUN cycles.
    task automatic serve(input int k, input int gap, input bit noise);
        int c;
        int n;
        c = 0;
        n = 0;
        last_cyc = 0;
        step();
        while (n < k && c < 300) begin
            c++;
            if ($urandom_range(0, gap) == 0) begin
                res_valid_in = 1'b1;
                res_data_in  = $urandom;
                exp_q.push_back(res_data_in);
                n++;
                if (n == k) last_cyc = c;
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                host.word_valid_in = 1'b1;
                host.word_in = ($urandom_range(0, 3) == 0) ? SENTINEL : $urandom;
            end
            step();
            res_valid_in       = 1'b0;
            host.word_valid_in = 1'b0;
        end
        chk("serve_budget", n, k);
        chk("cycles", cycles_out, last_cyc);
        if (noise && $urandom_range(0, 1) == 0) begin
            res_valid_in = 1'b1;
            res_data_in  = $urandom;
            step();
            res_valid_in = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            guard++;
            if (host.result_valid_out !== 1'b1) begin
                chk({tag, "_valid"}, host.result_valid_out, 1);
                exp_q.delete();
            end else if ($urandom_range(0, 2) != 0) begin
                chk({tag, "_data"}, host.result_out, exp_q[0]);
                host.rd_in = 1'b1;
                step();
                host.rd_in = 1'b0;
                void'(exp_q.pop_front());
            end else begin
                step();
            end
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        guard = 0;
        while (!done_out && guard < 8) begin
            host.rd_in = 1'($urandom_range(0, 1));
            step();
            host.rd_in = 1'b0;
            guard++;
        end
        chk({tag, "_done"}, done_out, 1);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_rv"}, host.result_valid_out, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_err"}, error_out, 0);
        chk({tag, "_start"}, start_out, 0);
        chk({tag, "_cyc"}, cycles_out, 0);
        chk({tag, "_k"}, 32'(k_out), 0);
        chk({tag, "_vid"}, vertex_id_out, 0);
        for (int i = 0; i < DIM; i++) chk({tag, "_q"}, query_out[i], 0);
        chk({tag, "_rv"}, host.result_valid_out, 0);
        chk({tag, "_res"}, host.result_out, 0);
    endtask

    initial begin
        qvec_t q;
        logic [31:0] vid;
        logic [31:0] kw;
        logic [31:0] tmp;
        int s0;
        int kr;
        bit ok;

        host.word_in       = '0;
        host.word_valid_in = 1'b0;
        host.rd_in         = 1'b0;
        res_data_in        = '0;
        res_valid_in       = 1'b0;

        tbl[0] = '{kw: 32'd0,          ok: 1'b0};
        tbl[1] = '{kw: 32'd9,          ok: 1'b0};
        tbl[2] = '{kw: 32'h0001_0000,  ok: 1'b0};
        tbl[3] = '{kw: 32'd1,          ok: 1'b1};
        tbl[4] = '{kw: 32'd8,          ok: 1'b1};
        tbl[5] = '{kw: 32'hABCD_0003,  ok: 1'b1};
        tbl[6] = '{kw: 32'h0000_FFFF,  ok: 1'b0};

        step();
        step();
        chk_reset_outs("rst");
        rst_in = 1'b1;
        step();

        // Directed frame {5,7,1,1}, k=2, vid=3; results 9 and 4 at RUN cycles 3 and 6.
        q = {32'd1, 32'd1, 32'd7, 32'd5};
        s0 = starts;
        send_frame(q, 32'd2, 32'd3, 1'b0);
        chk_launch(q, 32'd2, 32'd3);
        step();
        for (int c = 1; c <= 6; c++) begin
            res_valid_in = (c == 3 || c == 6);
            res_data_in  = (c == 3) ? 32'd9 : 32'd4;
            step();
            res_valid_in = 1'b0;
        end
        chk("dir_cycles", cycles_out, 6);
        chk("dir_rv", host.result_valid_out, 1);
        chk("dir_res0", host.result_out, 9);
        host.rd_in = 1'b1;
        step();
        chk("dir_res1", host.result_out, 4);
        step();
        host.rd_in = 1'b0;
        step();
        chk("dir_done", done_out, 1);
        chk("dir_busy", busy_out, 0);
        chk("dir_cyc_hold", cycles_out, 6);
        chk("dir_starts", starts - s0, 1);

        // Table of k values: legal ones run a query, illegal ones flag error.
        foreach (tbl[t]) begin
            for (int i = 0; i < DIM; i++) q[i] = rnd_word();
            vid = rnd_word();
            s0 = starts;
            send_frame(q, tbl[t].kw, vid, 1'b0);
            if (tbl[t].ok) begin
                chk_launch(q, tbl[t].kw, vid);
                serve(int'(tbl[t].kw[15:0]), 2, 1'b0);
                drain("tbl");
                chk("tbl_starts", starts - s0, 1);
            end else begin
                chk("tbl_err", error_out, 1);
                chk("tbl_busy", busy_out, 0);
                step();
                step();
                chk("tbl_nostart", starts - s0, 0);
            end
        end

        // Frame restarted by a sentinel after 3 words.
        send(SENTINEL);
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        send(32'hAAAA_0003);
        q = {32'h44, 32'h33, 32'h22, 32'h11};
        s0 = starts;
        send_frame(q, 32'd1, 32'h55, 1'b0);
        chk_launch(q, 32'd1, 32'h55);
        serve(1, 0, 1'b0);
        drain("rst_frame");
        chk("restart_starts", starts - s0, 1);

        // Sentinel in DRAIN flushes and reloads without a second sentinel.
        q = {32'h4, 32'h3, 32'h2, 32'h1};
        send_frame(q, 32'd2, 32'h9, 1'b0);
        serve(2, 1, 1'b0);
        send(SENTINEL);
        exp_q.delete();
        chk("flush_rv", host.result_valid_out, 0);
        chk("flush_busy", busy_out, 1);
        chk("flush_done", done_out, 0);
        q = {32'h8, 32'h7, 32'h6, 32'h5};
        s0 = starts;
        send_body(q, 32'd1, 32'hA, 1'b0);
        chk_launch(q, 32'd1, 32'hA);
        serve(1, 1, 1'b0);
        drain("flush");
        chk("flush_starts", starts - s0, 1);

        // Reset while in RUN.
        send_frame(q, 32'd3, 32'hB, 1'b0);
        step();
        step();
        step();
        rst_in = 1'b0;
        #1;
        chk_reset_outs("rst_run");
        s0 = starts;
        step();
        rst_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            res_valid_in = 1'b1;
            res_data_in  = 32'h77;
            step();
        end
        res_valid_in = 1'b0;
        chk("rst_run_rv", host.result_valid_out, 0);
        chk("rst_run_busy", busy_out, 0);
        chk("rst_run_nostart", starts - s0, 0);

        // Reset while in DRAIN with one entry left.
        send_frame(q, 32'd2, 32'hC, 1'b0);
        serve(2, 0, 1'b0);
        host.rd_in = 1'b1;
        step();
        host.rd_in = 1'b0;
        chk("drn_one_left", host.result_valid_out, 1);
        rst_in = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outs("rst_drn");
        step();
        rst_in = 1'b1;
        res_valid_in = 1'b1;
        step();
        res_valid_in = 1'b0;
        step();
        chk("rst_drn_rv", host.result_valid_out, 0);

        // Random queries against the frame/result model.
        for (int it = 0; it < 25; it++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) send(rnd_word());
            for (int i = 0; i < DIM; i++) q[i] = rnd_word();
            vid = rnd_word();
            if ($urandom_range(0, 5) == 0)
                kr = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 40);
            else
                kr = $urandom_range(1, MAX_K);
            tmp = $urandom;
            kw = {tmp[31:16], 16'(kr)};
            ok = (kr >= 1) && (kr <= MAX_K);
            s0 = starts;
            send_frame(q, kw, vid, 1'b1);
            if (ok) begin
                chk_launch(q, kw, vid);
                serve(kr, 3, 1'b1);
                drain("rnd");
                chk("rnd_starts", starts - s0, 1);
            end else begin
                chk("rnd_err", error_out, 1);
                chk("rnd_busy", busy_out, 0);
                step();
                chk("rnd_nostart", starts - s0, 0);
            end
        end

`ifdef BFIS_CTRL_TIMEOUT_EN
        // Watchdog: k=3 but only one result ever arrives.
        begin
            int guard;
            send_frame(q, 32'd3, 32'hD, 1'b0);
            step();
            guard = 0;
            while (!error_out && guard < 40) begin
                res_valid_in = (guard == 1);
                res_data_in  = 32'h1234;
                step();
                res_valid_in = 1'b0;
                guard++;
            end
            exp_q.push_back(32'h1234);
            chk("tmo_err", error_out, 1);
            chk("tmo_cycles", cycles_out, 20);
            drain("tmo");
            chk("tmo_err_hold", error_out, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
